// File: rtl/delay_sa_pkg.sv
// Shared types and elaboration helpers for the delay_sa per-channel delay stage.
package delay_sa_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_e;

   function automatic int delay_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int ch_width(input int num_channels);
      return (num_channels > 1) ? $clog2(num_channels) : 1;
   endfunction

   // LSB of channel ch inside a packed multi-channel sample vector.
   function automatic int ch_lsb(input int ch, input int data_width);
      return ch * data_width;
   endfunction

endpackage

// File: rtl/delay_sa_ring.sv
// One channel's ring buffer: single write port, single registered read port.
module delay_sa_ring #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 32,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Contents survive reset so history is never lost to a reset pulse.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/delay_sa.sv
// Per-channel delay stage driving the summ_sa start/beat/done sequence.
// Optional DELAY_SA_ZERO_FILL_EN masks beats whose delay reaches past written history.
module delay_sa
   import delay_sa_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int NUM_CHANNELS = 4,
   parameter int DEPTH        = 32,
   parameter int DELAY_WIDTH  = delay_width(DEPTH),
   parameter int CH_WIDTH     = ch_width(NUM_CHANNELS)
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_samples,
   input  logic                             delay_wr_en,
   input  logic [CH_WIDTH-1:0]              delay_wr_ch,
   input  logic [DELAY_WIDTH-1:0]           delay_wr_val,
   output logic                             start_sum,
   output logic                             sum_en,
   output logic [DATA_WIDTH-1:0]            delayed_sample,
   output logic                             done_channel,
   output logic                             busy
);

   state_e                state_q, state_d;
   logic [CH_WIDTH-1:0]    ch_q, ch_d;
   logic [DELAY_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [DELAY_WIDTH-1:0] shadow_q [NUM_CHANNELS];
   logic [DELAY_WIDTH-1:0] active_q [NUM_CHANNELS];
   logic                   start_sum_q, start_sum_d;
   logic                   sum_en_q, sum_en_d;
   logic                   done_q, done_d;
   logic                   busy_q, busy_d;
   logic                   in_ready_q, in_ready_d;

   logic                   accept;
   logic                   last_beat;
   logic                   rd_en;
   logic [CH_WIDTH-1:0]    rd_ch;
   logic [DELAY_WIDTH-1:0] rd_addr;
   logic                   beat_mask;
   logic [NUM_CHANNELS-1:0] wr_hit;
   logic [DATA_WIDTH-1:0]  ring_rdata [NUM_CHANNELS];

   assign accept    = (state_q == IDLE) && in_valid;
   assign last_beat = (ch_q == CH_WIDTH'(NUM_CHANNELS - 1));
   assign rd_addr   = wr_ptr_q - active_q[rd_ch];

   // Each ring is read one cycle ahead of the beat that presents its data.
   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      wr_ptr_d    = wr_ptr_q;
      sum_en_d    = 1'b0;
      done_d      = 1'b0;
      rd_en       = 1'b0;
      rd_ch       = '0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = START;
            end
         end
         START: begin
            state_d  = STREAM;
            ch_d     = '0;
            sum_en_d = 1'b1;
            rd_en    = 1'b1;
            rd_ch    = '0;
         end
         STREAM: begin
            if (last_beat) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               ch_d     = ch_q + CH_WIDTH'(1);
               sum_en_d = 1'b1;
               rd_en    = 1'b1;
               rd_ch    = ch_q + CH_WIDTH'(1);
            end
         end
         DONE: begin
            state_d  = IDLE;
            wr_ptr_d = wr_ptr_q + DELAY_WIDTH'(1);
         end
         default: state_d = IDLE;
      endcase
      start_sum_d = (state_d == START);
      busy_d      = (state_d != IDLE);
      in_ready_d  = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         ch_q        <= '0;
         wr_ptr_q    <= '0;
         start_sum_q <= 1'b0;
         sum_en_q    <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         wr_ptr_q    <= wr_ptr_d;
         start_sum_q <= start_sum_d;
         sum_en_q    <= sum_en_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         in_ready_q  <= in_ready_d;
      end
   end

   // A write landing on the accept cycle bypasses the shadow into the active table.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NUM_CHANNELS; k++) begin
            shadow_q[k] <= '0;
            active_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (wr_hit[k]) begin
               shadow_q[k] <= delay_wr_val;
            end
            if (accept) begin
               active_q[k] <= wr_hit[k] ? delay_wr_val : shadow_q[k];
            end
         end
      end
   end

   for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ring
      assign wr_hit[k] = delay_wr_en && (delay_wr_ch == CH_WIDTH'(k));

      delay_sa_ring #(
         .DATA_WIDTH(DATA_WIDTH),
         .DEPTH     (DEPTH),
         .AW        (DELAY_WIDTH)
      ) u_ring (
         .clk    (clk),
         .we_i   (accept),
         .waddr_i(wr_ptr_q),
         .wdata_i(in_samples[ch_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
         .re_i   (rd_en && (rd_ch == CH_WIDTH'(k))),
         .raddr_i(rd_addr),
         .rdata_o(ring_rdata[k])
      );
   end

`ifdef DELAY_SA_ZERO_FILL_EN
   logic [DELAY_WIDTH:0] fill_q;
   logic                 mask_q;

   // The current frame counts as history, so a delay equal to the fill count is valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fill_q <= '0;
         mask_q <= 1'b0;
      end else begin
         if ((state_q == DONE) && (fill_q != (DELAY_WIDTH+1)'(DEPTH))) begin
            fill_q <= fill_q + (DELAY_WIDTH+1)'(1);
         end
         if (rd_en) begin
            mask_q <= ({1'b0, active_q[rd_ch]} > fill_q);
         end
      end
   end

   assign beat_mask = mask_q;
`else
   assign beat_mask = 1'b0;
`endif

   assign delayed_sample = (sum_en_q && !beat_mask) ? ring_rdata[ch_q] : '0;
   assign start_sum      = start_sum_q;
   assign sum_en         = sum_en_q;
   assign done_channel   = done_q;
   assign busy           = busy_q;
   assign in_ready       = in_ready_q;

endmodule
